// File: rtl/fll_cfg_if.sv
// Bridge between a req/gnt register port and the FLL CFGREQ/CFGACK four-phase handshake.
// CFGACK and LOCK are resynchronized; a cycle counter aborts a transaction whose handshake stalls.
module fll_cfg_if #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_req_i,
   output logic        cfg_gnt_o,
   input  logic [1:0]  cfg_add_i,
   input  logic        cfg_wen_i,
   input  logic [31:0] cfg_wdata_i,
   output logic        cfg_r_valid_o,
   output logic [31:0] cfg_r_rdata_o,
   output logic        cfg_r_err_o,
   output logic        fll_cfgreq_o,
   output logic [1:0]  fll_cfgad_o,
   output logic [31:0] fll_cfgd_o,
   output logic        fll_cfgweb_o,
   input  logic        fll_cfgack_i,
   input  logic [31:0] fll_cfgq_i,
   input  logic        fll_lock_i,
   output logic        lock_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW, RESP} state_e;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync_q, lock_sync_q;
   logic                   ack_s;
   logic                   cfgreq_q, cfgreq_d;
   logic [1:0]             cfgad_q, cfgad_d;
   logic [31:0]            cfgd_q, cfgd_d;
   logic                   cfgweb_q, cfgweb_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   timeout;

   assign ack_s   = ack_sync_q[SYNC_STAGES-1];
   assign timeout = (cnt_q == TO_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_sync_q  <= '0;
         lock_sync_q <= '0;
         state_q     <= IDLE;
         cfgreq_q    <= 1'b0;
         cfgad_q     <= 2'd0;
         cfgd_q      <= 32'd0;
         cfgweb_q    <= 1'b1;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         cnt_q       <= 16'd0;
      end else begin
         ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], fll_cfgack_i};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], fll_lock_i};
         state_q     <= state_d;
         cfgreq_q    <= cfgreq_d;
         cfgad_q     <= cfgad_d;
         cfgd_q      <= cfgd_d;
         cfgweb_q    <= cfgweb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cfgreq_d = cfgreq_q;
      cfgad_d  = cfgad_q;
      cfgd_d   = cfgd_q;
      cfgweb_d = cfgweb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;

      if ((state_q == REQ) || (state_q == WAIT_LOW)) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (cfg_req_i && cfg_gnt_o) begin
               cfgad_d  = cfg_add_i;
               cfgd_d   = cfg_wdata_i;
               cfgweb_d = cfg_wen_i;
               cfgreq_d = 1'b1;
               err_d    = 1'b0;
               cnt_d    = 16'd0;
               state_d  = REQ;
            end
         end
         REQ: begin
            // Handshake progress is tested before the timeout so it wins a tie.
            if (ack_s) begin
               cfgreq_d = 1'b0;
               rdata_d  = cfgweb_q ? fll_cfgq_i : 32'd0;
               err_d    = 1'b0;
               state_d  = WAIT_LOW;
            end else if (timeout) begin
               cfgreq_d = 1'b0;
               rdata_d  = 32'd0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         WAIT_LOW: begin
            if (!ack_s) begin
               state_d = RESP;
            end else if (timeout) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding off the grant while ack_s is high keeps a stuck or slow ack from an
   // aborted transaction from being mistaken for the next one's handshake.
   assign cfg_gnt_o     = (state_q == IDLE) && !ack_s;
   assign cfg_r_valid_o = (state_q == RESP);
   assign cfg_r_rdata_o = rdata_q;
   assign cfg_r_err_o   = err_q;
   assign fll_cfgreq_o  = cfgreq_q;
   assign fll_cfgad_o   = cfgad_q;
   assign fll_cfgd_o    = cfgd_q;
   assign fll_cfgweb_o  = cfgweb_q;
   assign lock_o        = lock_sync_q[SYNC_STAGES-1];
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_fll_cfg_if.sv
// Bench for fll_cfg_if: behavioural FLL with programmable ack delays, timing/response
// predicted from handshake arithmetic, plus directed timeout, stuck-ack, lock and reset steps.
module tb_fll_cfg_if;

   localparam int TO = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cfg_req_i;
   logic        cfg_gnt_o;
   logic [1:0]  cfg_add_i;
   logic        cfg_wen_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_r_valid_o;
   logic [31:0] cfg_r_rdata_o;
   logic        cfg_r_err_o;
   logic        fll_cfgreq_o;
   logic [1:0]  fll_cfgad_o;
   logic [31:0] fll_cfgd_o;
   logic        fll_cfgweb_o;
   logic        fll_cfgack_i;
   logic [31:0] fll_cfgq_i;
   logic        fll_lock_i;
   logic        lock_o;
   logic        busy_o;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   int          fll_d = 0;
   int          fll_e = 0;
   logic [31:0] fll_qv = 32'd0;
   int          n_gnt = 0;
   int          n_val = 0;

   fll_cfg_if #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_add_i(cfg_add_i),
      .cfg_wen_i(cfg_wen_i), .cfg_wdata_i(cfg_wdata_i),
      .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_rdata_o(cfg_r_rdata_o), .cfg_r_err_o(cfg_r_err_o),
      .fll_cfgreq_o(fll_cfgreq_o), .fll_cfgad_o(fll_cfgad_o), .fll_cfgd_o(fll_cfgd_o),
      .fll_cfgweb_o(fll_cfgweb_o), .fll_cfgack_i(fll_cfgack_i), .fll_cfgq_i(fll_cfgq_i),
      .fll_lock_i(fll_lock_i), .lock_o(lock_o), .busy_o(busy_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   // FLL model: ack rises d cycles after req is seen, falls e cycles after req drops
   initial begin
      int  cnt = 0;
      int  cd  = 0;
      int  ce  = 0;
      bit  started = 0;
      fll_cfgack_i = 1'b0;
      fll_cfgq_i   = 32'd0;
      forever begin
         @(negedge clk_i);
         if (!fll_cfgreq_o && !fll_cfgack_i) begin
            started = 0;
            cnt     = 0;
         end else if (fll_cfgreq_o && !fll_cfgack_i) begin
            if (!started) begin
               started = 1; cd = fll_d; ce = fll_e; cnt = 0;
            end
            if (cnt >= cd) begin
               fll_cfgack_i = 1'b1; fll_cfgq_i = fll_qv; cnt = 0;
            end else cnt++;
         end else if (!fll_cfgreq_o && fll_cfgack_i) begin
            if (cnt >= ce) begin
               fll_cfgack_i = 1'b0; fll_cfgq_i = $urandom; cnt = 0; started = 0;
            end else cnt++;
         end
      end
   end

   // count accepted requests and response strobes
   initial begin
      forever begin
         @(negedge clk_i);
         #1;
         if (rst_ni && cfg_req_i && cfg_gnt_o) n_gnt++;
         if (cfg_r_valid_o) n_val++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Timing from the handshake: ack lands in cycle 1+d, is seen two cycles later,
   // req drops the cycle after, ack falls e cycles later and is seen two cycles after that.
   function automatic void predict(input int d, input int e, output int resp,
                                   output int req_last, output bit err);
      int h, w;
      h = d + 3;
      if (d + 1 > TO || h > TO) begin
         resp = TO + 1; req_last = TO; err = 1'b1;
      end else begin
         w = h + 3 + e;
         req_last = h;
         if (w <= TO) begin
            resp = w + 1; err = 1'b0;
         end else begin
            resp = TO + 1; err = 1'b1;
         end
      end
   endfunction

   // driver: one transaction, checked cycle by cycle against the prediction
   task automatic run_txn(input logic wen, input logic [1:0] add, input logic [31:0] wd,
                          input logic [31:0] qv, input int d, input int e, input bit keep,
                          output int wait_n);
      int          resp, req_last, n;
      bit          err, seen;
      logic [31:0] exp_rd;
      predict(d, e, resp, req_last, err);
      exp_rd = err ? 32'd0 : (wen ? qv : 32'd0);
      fll_d = d; fll_e = e; fll_qv = qv;
      cfg_req_i = 1'b1; cfg_wen_i = wen; cfg_add_i = add; cfg_wdata_i = wd;
      n = 0;
      while (!cfg_gnt_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      wait_n = n;
      if (!cfg_gnt_o) begin
         chk("gnt_wait", 32'(cfg_gnt_o), 32'd1);
         cfg_req_i = 1'b0;
         return;
      end
      exp_q.push_back(exp_rd);
      @(negedge clk_i);
      if (!keep) cfg_req_i = 1'b0;
      cfg_add_i   = 2'($urandom_range(3, 0));
      cfg_wen_i   = 1'($urandom_range(1, 0));
      cfg_wdata_i = $urandom;
      seen = 0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         chk("req_level", 32'(fll_cfgreq_o), 32'(c <= req_last));
         if (fll_cfgreq_o) begin
            chk("cfgad", 32'(fll_cfgad_o), 32'(add));
            chk("cfgd", fll_cfgd_o, wd);
            chk("cfgweb", 32'(fll_cfgweb_o), 32'(wen));
         end
         chk("busy", 32'(busy_o), 32'd1);
         chk("valid_with_gnt", 32'(cfg_r_valid_o & cfg_gnt_o), 32'd0);
         if (cfg_r_valid_o) begin
            seen = 1;
            chk("resp_cycle", c, resp);
            chk("rdata", cfg_r_rdata_o, exp_q.pop_front());
            chk("err", 32'(cfg_r_err_o), 32'(err));
         end else begin
            @(negedge clk_i);
         end
      end
      if (!seen) begin
         chk("resp_seen", 32'(seen), 32'd1);
         void'(exp_q.pop_front());
      end
      @(negedge clk_i);
      chk("busy_after", 32'(busy_o), 32'd0);
      chk("valid_one_cycle", 32'(cfg_r_valid_o), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_cfgreq"}, 32'(fll_cfgreq_o), 32'd0);
      chk({pfx, "_cfgad"}, 32'(fll_cfgad_o), 32'd0);
      chk({pfx, "_cfgd"}, fll_cfgd_o, 32'd0);
      chk({pfx, "_cfgweb"}, 32'(fll_cfgweb_o), 32'd1);
      chk({pfx, "_valid"}, 32'(cfg_r_valid_o), 32'd0);
      chk({pfx, "_rdata"}, cfg_r_rdata_o, 32'd0);
      chk({pfx, "_err"}, 32'(cfg_r_err_o), 32'd0);
      chk({pfx, "_lock"}, 32'(lock_o), 32'd0);
      chk({pfx, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int w, g0, v0, n, d, e;
      rst_ni = 1'b0; cfg_req_i = 1'b0; cfg_add_i = 2'd0; cfg_wen_i = 1'b0;
      cfg_wdata_i = 32'd0; fll_lock_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("rst");
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      // zero-delay write and read
      run_txn(1'b0, 2'd2, 32'hC0FFEE01, $urandom, 0, 0, 1'b0, w);
      run_txn(1'b1, 2'd1, $urandom, 32'h1234ABCD, 0, 0, 1'b0, w);
      // ack falling exactly on the timeout cycle wins; one cycle later it loses
      run_txn(1'b1, 2'd3, $urandom, 32'hA5A55A5A, 1, 1, 1'b0, w);
      run_txn(1'b1, 2'd0, $urandom, 32'h0BADF00D, 2, 1, 1'b0, w);
      // ack never rises
      run_txn(1'b1, 2'd2, $urandom, 32'h55AA55AA, 20, 0, 1'b0, w);
      // ack stuck high past the timeout: next grant waits for ack_s to fall
      run_txn(1'b0, 2'd1, 32'h11112222, $urandom, 0, 20, 1'b0, w);
      run_txn(1'b1, 2'd3, $urandom, 32'h87654321, 0, 0, 1'b0, w);
      chk("stuck_gnt_wait", w, 16);

      for (int i = 0; i < 12; i++) begin
         d = $urandom_range(3, 0);
         e = $urandom_range(3, 0);
         run_txn(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom, $urandom,
                 d, e, 1'b0, w);
      end

      // back-to-back with cfg_req_i held high
      g0 = n_gnt; v0 = n_val;
      run_txn(1'b1, 2'd0, $urandom, 32'hAAAA0001, 0, 0, 1'b1, w);
      run_txn(1'b0, 2'd1, 32'hBBBB0002, $urandom, 0, 0, 1'b1, w);
      chk("b2b_gnt_wait", w, 0);
      run_txn(1'b1, 2'd2, $urandom, 32'hCCCC0003, 0, 0, 1'b0, w);
      chk("b2b_gnt_wait", w, 0);
      chk("b2b_grants", n_gnt - g0, 3);
      chk("b2b_valids", n_val - v0, 3);

      // lock synchronizer latency
      fll_lock_i = 1'b1;
      @(negedge clk_i);
      chk("lock_early", 32'(lock_o), 32'd0);
      @(negedge clk_i);
      chk("lock_rise", 32'(lock_o), 32'd1);

      // reset in the middle of REQ
      fll_d = 0; fll_e = 0; fll_qv = $urandom;
      cfg_req_i = 1'b1; cfg_wen_i = 1'b0; cfg_add_i = 2'd3; cfg_wdata_i = 32'hDEADBEEF;
      n = 0;
      while (!cfg_gnt_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      @(negedge clk_i);
      cfg_req_i = 1'b0;
      @(negedge clk_i);
      chk("pre_reset_req", 32'(fll_cfgreq_o), 32'd1);
      #1 rst_ni = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      v0 = n_val;
      repeat (12) @(negedge clk_i);
      chk("no_resp_after_reset", n_val - v0, 0);
      chk("idle_after_reset", 32'(busy_o), 32'd0);
      run_txn(1'b1, 2'd1, $urandom, 32'h600DCAFE, 0, 0, 1'b0, w);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fll_cfg_if.md
FLL_CFG_IF -- requirements
Module: fll_cfg_if

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the fll_cfgack_i and fll_lock_i synchronizers; legal range 2..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in REQ plus WAIT_LOW before abort; legal range 8..65535.
REQ-003 clk_i  in  1  single system clock; all state is clocked on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cfg_req_i  in  1  upstream transaction request.
REQ-006 cfg_gnt_o  out  1  upstream grant; the transaction is accepted in the cycle cfg_req_i & cfg_gnt_o.
REQ-007 cfg_add_i  in  2  FLL register address.
REQ-008 cfg_wen_i  in  1  0 = write, 1 = read.
REQ-009 cfg_wdata_i  in  32  write data.
REQ-010 cfg_r_valid_o  out  1  one-cycle response strobe.
REQ-011 cfg_r_rdata_o  out  32  read data, valid with cfg_r_valid_o.
REQ-012 cfg_r_err_o  out  1  timeout error, valid with cfg_r_valid_o.
REQ-013 fll_cfgreq_o  out  1  FLL CFGREQ.
REQ-014 fll_cfgad_o / fll_cfgd_o / fll_cfgweb_o  out  2/32/1  FLL CFGAD, CFGD and CFGWEB.
REQ-015 fll_cfgack_i  in  1  FLL CFGACK, asynchronous to clk_i.
REQ-016 fll_cfgq_i  in  32  FLL CFGQ, stable while CFGACK is high.
REQ-017 fll_lock_i  in  1  FLL LOCK, asynchronous to clk_i.
REQ-018 lock_o  out  1  synchronized LOCK.
REQ-019 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-020 The block SHALL pass fll_cfgack_i and fll_lock_i each through SYNC_STAGES flip-flops; ack_s denotes the synchronized ack, and lock_o SHALL be the synchronizer output.
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT_LOW and RESP.
REQ-022 cfg_gnt_o SHALL equal (state==IDLE & ack_s==0); it is combinational and never depends on cfg_req_i.
REQ-023 On acceptance, the block SHALL register cfg_add_i, cfg_wdata_i and cfg_wen_i into fll_cfgad_o, fll_cfgd_o and fll_cfgweb_o, set fll_cfgreq_o to 1 and go to REQ at the next edge.
REQ-024 fll_cfgad_o, fll_cfgd_o and fll_cfgweb_o SHALL remain stable from acceptance until the next acceptance.
REQ-025 In REQ with ack_s==1, the block SHALL clear fll_cfgreq_o, capture rdata (fll_cfgq_i for a read, 32'h0 for a write) and go to WAIT_LOW.
REQ-026 In WAIT_LOW with ack_s==0, the block SHALL go to RESP.
REQ-027 In RESP, the block SHALL drive cfg_r_valid_o=1 for exactly one cycle with the captured rdata and err, then go to IDLE; there is no back-pressure.
REQ-028 A timeout counter SHALL clear on acceptance and increment each cycle in REQ or WAIT_LOW, saturating at its maximum.
REQ-029 When the counter equals TIMEOUT_CYCLES-1 and no transition occurs in that cycle, the block SHALL clear fll_cfgreq_o, set err=1 and rdata=0, and go to RESP.
REQ-030 Handshake progress in the same cycle as the timeout condition SHALL take priority over the timeout.
REQ-031 After a timeout, no new grant SHALL be issued until ack_s==0, per REQ-022.
REQ-032 err SHALL be 0 for any transaction that completes without timeout.
REQ-033 With SYNC_STAGES=2 and an FLL whose ack follows req with zero delay, taking the grant cycle as cycle 0: fll_cfgreq_o SHALL be high in cycles 1-3 and cfg_r_valid_o SHALL be high in cycle 7.
REQ-034 cfg_r_valid_o SHALL never be high in the same cycle as cfg_gnt_o.

Reset
REQ-035 While rst_ni is 0, the block SHALL go to IDLE and drive fll_cfgreq_o=0, fll_cfgad_o=0, fll_cfgd_o=0, fll_cfgweb_o=1, cfg_r_valid_o=0, cfg_r_rdata_o=0, cfg_r_err_o=0, lock_o=0, busy_o=0, and clear all synchronizer stages and the counter.
REQ-036 A reset asserted mid-transaction SHALL abort it with no response; the first grant after release SHALL wait for ack_s==0.

Verification
REQ-037 Write: zero-delay ack model, wen=0, add=2, wdata=32'hC0FFEE01 -> CFGAD=2, CFGD=32'hC0FFEE01 and CFGWEB=0 during req; r_valid in cycle 7 with rdata=0 and err=0.
REQ-038 Read: model returns CFGQ=32'h1234ABCD while ack is high, wen=1, add=1 -> r_valid in cycle 7 with rdata=32'h1234ABCD and err=0.
REQ-039 Timeout: ack held at 0, TIMEOUT_CYCLES=8 -> req high for 8 cycles, then r_valid with err=1 and rdata=0, and busy_o low the cycle after.
REQ-040 Stuck ack: after a timeout, ack held at 1 and cfg_req_i held at 1 -> cfg_gnt_o stays 0 until ack_s falls, then the grant is issued.
REQ-041 Lock: fll_lock_i 0->1 -> lock_o rises 2 cycles later; rst_ni pulled low mid-REQ -> all outputs at reset values immediately and no r_valid is produced.
REQ-042 Back-to-back: cfg_req_i held high for 3 transactions -> exactly 3 grants and 3 r_valid pulses, with each grant issued no earlier than the cycle after the previous r_valid.
